// File: rtl/fxfl_arb.sv
// Round-robin arbiter that shares one 7-bit fixed-to-float converter among NREQ
// requesters, with a single registered valid/ready result stage.
module fxfl_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [7*NREQ-1:0]    req_fx,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           out_m,
   output logic [3:0]           out_e,
   output logic [IDW-1:0]       out_id,
   output logic [CNTW-1:0]      conv_cnt
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gidx;
   logic [IDW-1:0] gnext;
   logic           found;
   logic           load;
   logic [6:0]     gfx;
   logic [7:0]     gconv;

   // Shift out redundant sign bits; each shift lowers the exponent by one.
   function automatic logic [7:0] conv(input logic [6:0] fx);
      logic [6:0] sh;
      logic [3:0] e;
      sh = fx;
      e  = 4'd0;
      if (fx != 7'd0) begin
         for (int k = 0; k < 6; k++) begin
            if (sh[6] == sh[5]) begin
               sh = sh << 1;
               e  = e - 4'd1;
            end
         end
      end
      return {sh[6:3], e};
   endfunction

   assign load = ~out_valid | out_ready;

   // Winner is the valid requester with the smallest rotational distance from ptr.
   always_comb begin
      int best;
      int d;
      best  = NREQ;
      d     = 0;
      gidx  = '0;
      found = 1'b0;
      if (load && !rst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
               d = i - int'(ptr);
               if (d < 0) d = d + NREQ;
               if (d < best) begin
                  best = d;
                  gidx = IDW'(i);
               end
            end
         end
         found = (best < NREQ);
      end
   end

   always_comb begin
      req_ready = '0;
      gfx       = 7'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (found && int'(gidx) == i) begin
            req_ready[i] = 1'b1;
            gfx          = req_fx[7*i +: 7];
         end
      end
   end

   assign gconv = conv(gfx);
   assign gnext = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);

   // Priority only rotates on an actual grant, never on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_m     <= 4'd0;
         out_e     <= 4'd0;
         out_id    <= '0;
         conv_cnt  <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (found) begin
            out_valid <= 1'b1;
            out_m     <= gconv[7:4];
            out_e     <= gconv[3:0];
            out_id    <= gidx;
            conv_cnt  <= conv_cnt + CNTW'(1);
            ptr       <= gnext;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fxfl_arb.sv
// Self-checking bench for fxfl_arb: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration and conversion.
module tb_fxfl_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [7*NREQ-1:0]   req_fx = '0;
   logic [NREQ-1:0]     req_ready;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [3:0]          out_m;
   logic [3:0]          out_e;
   logic [IDW-1:0]      out_id;
   logic [CNTW-1:0]     conv_cnt;

   int tests = 0;
   int fails = 0;

   logic       mv = 1'b0;
   logic [3:0] mm = 4'd0;
   logic [3:0] me = 4'd0;
   logic [1:0] mid = 2'd0;
   int         mcnt = 0;
   int         mptr = 0;
   int         last_grant = -1;

   fxfl_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_fx(req_fx),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_m(out_m), .out_e(out_e), .out_id(out_id), .conv_cnt(conv_cnt)
   );

   always #5 clk = ~clk;

   // Value fx/32 scaled by 2^k until it lands in [1,2) or [-2,-1); mantissa is floor of quarter units.
   function automatic logic [7:0] model_conv(input logic [6:0] fx);
      int w;
      int k;
      int m;
      w = int'($signed(fx));
      if (w == 0) return 8'h00;
      k = 0;
      while (!((w >= 32 && w < 64) || (w >= -64 && w < -32)) && k < 8) begin
         w = w * 2;
         k++;
      end
      m = w >>> 3;
      return {4'(m), 4'(-k)};
   endfunction

   function automatic int exp_grant(input logic [NREQ-1:0] v, input int p, input logic ld, input logic r);
      if (r || !ld) return -1;
      for (int j = 0; j < NREQ; j++)
         if (v[(p + j) % NREQ]) return (p + j) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready(input int g);
      logic [NREQ-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      int g;
      logic ld;
      logic [6:0] fxg;
      ld  = !mv || out_ready;
      g   = exp_grant(req_valid, mptr, ld, rst);
      fxg = 7'd0;
      if (g >= 0) fxg = req_fx[g*7 +: 7];
      @(posedge clk);
      #1;
      if (rst) begin
         mv = 1'b0; mm = 4'd0; me = 4'd0; mid = 2'd0; mcnt = 0; mptr = 0; g = -1;
      end else if (ld) begin
         if (g >= 0) begin
            {mm, me} = model_conv(fxg);
            mv   = 1'b1;
            mid  = 2'(g);
            mcnt = (mcnt + 1) % (1 << CNTW);
            mptr = (g + 1) % NREQ;
         end else begin
            mv = 1'b0;
         end
      end
      last_grant = g;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; req_fx = 28'($urandom); out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
         tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
         tests++; if (conv_cnt !== 4'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d want 0", conv_cnt); end
         tests++; if (out_m !== 4'd0 || out_e !== 4'd0 || out_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_regs: got m=%h e=%h id=%0d want 0", out_m, out_e, out_id); end
      end
      rst = 1'b0;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL reset_first_ready: got %b want 0001", req_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_first_grant: got v=%b id=%0d want v=1 id=0", out_valid, out_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_format();
      logic [6:0] fxs [6];
      logic [7:0] exps [6];
      fxs  = '{7'h20, 7'h01, 7'h7F, 7'h40, 7'h00, 7'h3F};
      exps = '{8'h40, 8'h4B, 8'h8A, 8'h80, 8'h00, 8'h70};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid = 4'b0001;
         req_fx[6:0] = fxs[i];
         #1;
         tests++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL format_ready[%0d]: got %b want 0001", i, req_ready); end
         tick();
         tests++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin fails++; $display("[TB] FAIL format_vid[%0d]: got v=%b id=%0d want v=1 id=0", i, out_valid, out_id); end
         tests++; if ({out_m, out_e} !== exps[i]) begin fails++; $display("[TB] FAIL format_me[%0d] fx=%h: got %h want %h", i, fxs[i], {out_m, out_e}, exps[i]); end
      end
      req_valid = '0;
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL format_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_fairness();
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = '1; req_fx = 28'($urandom); out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++; if (out_id !== 2'(i % 4) || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL fair_id[%0d]: got v=%b id=%0d want v=1 id=%0d", i, out_valid, out_id, i % 4); end
         tests++; if ({out_m, out_e} !== {mm, me}) begin fails++; $display("[TB] FAIL fair_me[%0d]: got %h want %h", i, {out_m, out_e}, {mm, me}); end
         req_fx[last_grant*7 +: 7] = 7'($urandom);
      end
      tests++; if (conv_cnt !== 4'd8) begin fails++; $display("[TB] FAIL fair_cnt: got %0d want 8", conv_cnt); end
   endtask

   task automatic test_backpressure();
      req_valid = 4'b0110; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); end
         tick();
         tests++; if (out_valid !== 1'b1 || out_id !== 2'd3 || {out_m, out_e} !== {mm, me}) begin fails++; $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d me=%h want v=1 id=3 me=%h", i, out_valid, out_id, {out_m, out_e}, {mm, me}); end
      end
      out_ready = 1'b1;
      #1;
      tests++; if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL bp_release_ready: got %b want 0010", req_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_id !== 2'd1 || {out_m, out_e} !== {mm, me}) begin fails++; $display("[TB] FAIL bp_release: got v=%b id=%0d me=%h want v=1 id=1 me=%h", out_valid, out_id, {out_m, out_e}, {mm, me}); end
      req_valid = 4'b0100;
      tick();
      tests++; if (out_id !== 2'd2) begin fails++; $display("[TB] FAIL bp_next: got id=%0d want 2", out_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_sparse();
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b1;
      req_valid = 4'b0001; tick();
      req_valid = 4'b0010; tick();
      req_valid = 4'b0010; req_fx[13:7] = 7'($urandom);
      #1;
      tests++; if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL sparse_ready: got %b want 0010", req_ready); end
      tick();
      tests++; if (out_id !== 2'd1 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL sparse_grant: got v=%b id=%0d want v=1 id=1", out_valid, out_id); end
      req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (out_valid !== 1'b0 || out_id !== 2'd1 || {out_m, out_e} !== {mm, me}) begin fails++; $display("[TB] FAIL sparse_idle[%0d]: got v=%b id=%0d me=%h want v=0 id=1 me=%h", i, out_valid, out_id, {out_m, out_e}, {mm, me}); end
      end
      req_valid = '1;
      #1;
      tests++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL sparse_ptr: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_wrap_reset();
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = '1; out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         req_fx[last_grant*7 +: 7] = 7'($urandom);
      end
      tests++; if (conv_cnt !== 4'd1) begin fails++; $display("[TB] FAIL wrap_cnt: got %0d want 1", conv_cnt); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL wrap_valid: got %b want 1", out_valid); end
      rst = 1'b1; tick(); rst = 1'b0;
      tests++; if (out_valid !== 1'b0 || conv_cnt !== 4'd0) begin fails++; $display("[TB] FAIL midrst: got v=%b cnt=%0d want v=0 cnt=0", out_valid, conv_cnt); end
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL midrst_ptr: got %b want 0001", req_ready); end
      tick();
      tests++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL midrst_grant: got v=%b id=%0d want v=1 id=0", out_valid, out_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [NREQ-1:0] pending;
      int waitg [NREQ];
      int g;
      pending = '0;
      for (int i = 0; i < NREQ; i++) waitg[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) begin
               pending[i] = 1'b1;
               req_fx[i*7 +: 7] = 7'($urandom);
               waitg[i] = 0;
            end
         end
         req_valid = pending;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = exp_grant(req_valid, mptr, !mv || out_ready, rst);
         tests++; if (req_ready !== exp_ready(g)) begin fails++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready(g)); end
         tick();
         if (last_grant >= 0) begin
            for (int i = 0; i < NREQ; i++) if (pending[i]) waitg[i]++;
            tests++; if (waitg[last_grant] > NREQ) begin fails++; $display("[TB] FAIL rand_fair[%0d]: got wait=%0d want <=%0d", c, waitg[last_grant], NREQ); end
            pending[last_grant] = 1'b0;
         end
         tests++; if (out_valid !== mv || conv_cnt !== 4'(mcnt)) begin fails++; $display("[TB] FAIL rand_vc[%0d]: got v=%b cnt=%0d want v=%b cnt=%0d", c, out_valid, conv_cnt, mv, mcnt); end
         tests++; if ({out_m, out_e, out_id} !== {mm, me, mid}) begin fails++; $display("[TB] FAIL rand_data[%0d]: got %h/%0d want %h/%0d", c, {out_m, out_e}, out_id, {mm, me}, mid); end
      end
      req_valid = '0;
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_format();
      test_fairness();
      test_backpressure();
      test_sparse();
      test_wrap_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fxfl_arb.md
Name: fxfl_arb

Overview:
Round-robin arbiter and sequencer that shares one 7-bit fixed-to-float converter among NREQ requesters. Each requester presents a 7-bit two's-complement fixed-point sample over valid/ready. The block grants one requester per cycle, converts the sample, and returns the 4-bit mantissa, 4-bit exponent and requester id through a single registered valid/ready output stage. It sits between the fixed-point sample sources and the float consumer.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, id width, must be >= ceil(log2(NREQ))
CNTW, 16, width of the conversion counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester sample valid
req_fx  in  7*NREQ  packed samples, requester i on bits [7*i+6:7*i]
req_ready  out  NREQ  per-requester accept, at most one bit high
out_valid  out  1  converted result valid
out_ready  in  1  consumer accept
out_m  out  4  mantissa, two's complement, 2 fraction bits
out_e  out  4  exponent, two's complement
out_id  out  IDW  index of the requester that produced the result
conv_cnt  out  CNTW  number of accepted conversions

Behaviour:
- Only one clock and one reset. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_m=0, out_e=0, out_id=0, conv_cnt=0, round-robin pointer ptr=0.
- Reset asserted mid-operation discards any held result. There is no delayed valid after reset is released.
- Conversion format:
  - Input value is fx/32.
  - Output value is (m/4)*2^e.
  - Non-zero results are normalised so that m[3] != m[2]. Low bits are truncated.
  - fx=0 gives m=0, e=0.
  - Exponent range is -6..0.
  - Conversion is combinational, inside the same cycle as the grant.
- load = ~out_valid | out_ready. The output register may be written only when load is true.
- Grant selection:
  - When load=1 and req_valid is non-zero, g is the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 and all other req_ready bits are 0.
  - When load=0, req_ready is all zero.
  - req_ready is combinational from req_valid, ptr and load. It never depends on req_fx.
- On a transfer (req_valid[g] & req_ready[g]) at the clock edge:
  - out_m and out_e take conv(req_fx[g]), out_id=g, out_valid=1.
  - conv_cnt increments, wrapping from 2^CNTW-1 to 0.
  - ptr becomes (g+1) mod NREQ.
- When load=1 and there is no request: out_valid goes to 0 and ptr is unchanged. out_m, out_e and out_id hold their last values.
- When out_valid=1 and out_ready=0: out_m, out_e and out_id are held stable and no grant is issued.
- Simultaneous events:
  - out_ready=1 with a request present gives a back-to-back transfer, one result per cycle.
  - Throughput is 1 per cycle. Latency from grant to out_valid is exactly 1 cycle.
- Fairness: a requester holding req_valid high is granted within NREQ grants.
- Requester protocol: once req_valid[i] is raised it stays high with req_fx stable until req_ready[i]. The block does not check this.
- ptr is updated only on a grant. An idle cycle does not rotate priority.

Test Plan:
- Reset check: assert rst for 2 cycles while all req_valid=1. Required: out_valid=0, req_ready=0 during reset, conv_cnt=0. First grant after release goes to id 0.
- Format check: requester 0 sends, with out_ready=1, the sequence fx=0x20, 0x01, 0x7F, 0x40, 0x00, 0x3F. Required {m,e}: 0x40, 0x4B, 0x8A, 0x80, 0x00, 0x70. Each result appears one cycle after its grant, out_id=0 throughout.
- Round-robin fairness: NREQ=4, all req_valid held high, out_ready=1 for 8 cycles. Required out_id sequence: 0,1,2,3,0,1,2,3. conv_cnt=8.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles while requesters 1 and 2 are valid. Required: req_ready=0 and out_m, out_e, out_id stable throughout. When out_ready rises, the held result retires and the next grant issues in the same cycle.
- Sparse and priority-skip: ptr=2 and only requester 1 is valid. Required: requester 1 is granted and ptr becomes 2. Then idle cycles with out_ready=1. Required: out_valid drops to 0 and ptr stays at 2.
- Mid-operation reset and wrap: with CNTW=4, perform 17 transfers. Required: conv_cnt=1. Then assert rst while out_valid=1. Required: next cycle out_valid=0, conv_cnt=0, ptr=0.
